// File: rtl/i2c_state.sv
// i2c_state: write-only I2C master that plays the WM8731 register table once after reset.
// Optional feature macro I2C_ACK_CHECK_EN: a NACK retries the same table entry.
module i2c_state #(
  parameter int         QUARTER_CYCLES = 125,
  parameter logic [7:0] DEV_ADDR       = 8'h34
) (
  input  logic clk,
  input  logic KEY,
  output logic FPGA_I2C_SCLK,
  inout  wire  FPGA_I2C_SDAT
);

  localparam int QCW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [QCW-1:0] QC_LAST = QCW'(QUARTER_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_BYTE0 = 4'd2,
    ST_ACK0  = 4'd3,
    ST_BYTE1 = 4'd4,
    ST_ACK1  = 4'd5,
    ST_BYTE2 = 4'd6,
    ST_ACK2  = 4'd7,
    ST_STOP  = 4'd8,
    ST_GAP   = 4'd9,
    ST_DONE  = 4'd10
  } state_t;

  // Codec register words, {reg[6:0], data[8:0]}.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0C00;
      4'd2:    table_word = 16'h0017;
      4'd3:    table_word = 16'h0217;
      4'd4:    table_word = 16'h0479;
      4'd5:    table_word = 16'h0679;
      4'd6:    table_word = 16'h0812;
      4'd7:    table_word = 16'h0A00;
      4'd8:    table_word = 16'h0E02;
      4'd9:    table_word = 16'h1000;
      4'd10:   table_word = 16'h1201;
      default: table_word = 16'h0000;
    endcase
  endfunction

  logic           rst_s;
  state_t         state_r;
  state_t         state_nx_s;
  logic [QCW-1:0] qcnt_r;
  logic [1:0]     phase_r;
  logic [2:0]     bit_cnt_r;
  logic [3:0]     idx_r;
  logic           tick_s;
  logic           bit_end_s;
  logic           nack_s;
  logic [15:0]    word_s;
  logic [7:0]     cur_byte_s;
  logic           byte_bit_s;
  logic           sclk_s;
  logic           sda_low_s;
  logic           sclk_r;
  logic           sda_low_r;

  assign rst_s     = KEY;
  assign tick_s    = (qcnt_r == QC_LAST);
  assign bit_end_s = tick_s && (phase_r == 2'd3);
  assign word_s    = table_word(idx_r);

`ifdef I2C_ACK_CHECK_EN
  logic nack_r;
  logic in_ack_s;

  assign in_ack_s = (state_r == ST_ACK0) || (state_r == ST_ACK1) || (state_r == ST_ACK2);

  // Sample the acknowledge in q2 while SCLK is high; held until the retry decision in GAP.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      nack_r <= 1'b0;
    end else if (tick_s && (phase_r == 2'd2) && in_ack_s) begin
      nack_r <= (FPGA_I2C_SDAT != 1'b0);
    end else if (bit_end_s && (state_r == ST_GAP)) begin
      nack_r <= 1'b0;
    end else begin
      nack_r <= nack_r;
    end
  end

  assign nack_s = nack_r;
`else
  assign nack_s = 1'b0;
`endif

  // Quarter-tick timebase and q0..q3 phase within the current bit period.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      qcnt_r  <= '0;
      phase_r <= 2'd0;
    end else if (tick_s) begin
      qcnt_r  <= '0;
      phase_r <= phase_r + 2'd1;
    end else begin
      qcnt_r  <= qcnt_r + {{(QCW-1){1'b0}}, 1'b1};
      phase_r <= phase_r;
    end
  end

  // Bit position inside a byte and table index, both stepped at bit-period boundaries.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      bit_cnt_r <= 3'd0;
      idx_r     <= 4'd0;
    end else if (bit_end_s) begin
      if ((state_r == ST_BYTE0) || (state_r == ST_BYTE1) || (state_r == ST_BYTE2)) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= 3'd0;
      end
      if ((state_r == ST_GAP) && !nack_s && (idx_r != LAST_IDX)) begin
        idx_r <= idx_r + 4'd1;
      end else begin
        idx_r <= idx_r;
      end
    end else begin
      bit_cnt_r <= bit_cnt_r;
      idx_r     <= idx_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; every transition happens at the end of a bit period.
  always_comb begin
    state_nx_s = state_r;
    if (bit_end_s) begin
      case (state_r)
        ST_IDLE:  state_nx_s = ST_START;
        ST_START: state_nx_s = ST_BYTE0;
        ST_BYTE0: state_nx_s = (bit_cnt_r == 3'd7) ? ST_ACK0 : ST_BYTE0;
        ST_ACK0:  state_nx_s = nack_s ? ST_STOP : ST_BYTE1;
        ST_BYTE1: state_nx_s = (bit_cnt_r == 3'd7) ? ST_ACK1 : ST_BYTE1;
        ST_ACK1:  state_nx_s = nack_s ? ST_STOP : ST_BYTE2;
        ST_BYTE2: state_nx_s = (bit_cnt_r == 3'd7) ? ST_ACK2 : ST_BYTE2;
        ST_ACK2:  state_nx_s = ST_STOP;
        ST_STOP:  state_nx_s = ST_GAP;
        ST_GAP:   state_nx_s = (!nack_s && (idx_r == LAST_IDX)) ? ST_DONE : ST_START;
        ST_DONE:  state_nx_s = ST_DONE;
        default:  state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Byte being shifted; ~bit_cnt_r selects bit 7-n so bytes go out MSB first.
  always_comb begin
    cur_byte_s = DEV_ADDR;
    case (state_r)
      ST_BYTE1: cur_byte_s = word_s[15:8];
      ST_BYTE2: cur_byte_s = word_s[7:0];
      default:  cur_byte_s = DEV_ADDR;
    endcase
    byte_bit_s = cur_byte_s[~bit_cnt_r];
  end

  // Bus levels per state and quarter; SDAT only moves at q0 except in START/STOP.
  always_comb begin
    sclk_s    = 1'b1;
    sda_low_s = 1'b0;
    case (state_r)
      ST_START: begin
        sclk_s    = (phase_r != 2'd3);
        sda_low_s = phase_r[1];
      end
      ST_BYTE0, ST_BYTE1, ST_BYTE2: begin
        sclk_s    = phase_r[1];
        sda_low_s = ~byte_bit_s;
      end
      ST_ACK0, ST_ACK1, ST_ACK2: begin
        sclk_s    = phase_r[1];
        sda_low_s = 1'b0;
      end
      ST_STOP: begin
        sclk_s    = phase_r[1];
        sda_low_s = (phase_r != 2'd3);
      end
      default: begin
        sclk_s    = 1'b1;
        sda_low_s = 1'b0;
      end
    endcase
  end

  // Registered pin drivers so SCLK and SDAT are glitch-free.
  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      sclk_r    <= 1'b1;
      sda_low_r <= 1'b0;
    end else begin
      sclk_r    <= sclk_s;
      sda_low_r <= sda_low_s;
    end
  end

  assign FPGA_I2C_SCLK = sclk_r;
  assign FPGA_I2C_SDAT = sda_low_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_state.sv
// tb_i2c_state: directed bench with a sampled I2C decoder and an ACK pull-down model.
module tb_i2c_state;

  localparam int QC = 2;

  logic clk;
  logic key;
  logic sclk;
  wire  sdat;
  logic ack_pull = 1'b0;
  logic pull_en  = 1'b1;
  logic dec_clr  = 1'b1;

  pullup (sdat);
  assign sdat = ack_pull ? 1'b0 : 1'bz;

  i2c_state #(.QUARTER_CYCLES(QC), .DEV_ADDR(8'h34)) dut (
    .clk           (clk),
    .KEY           (key),
    .FPGA_I2C_SCLK (sclk),
    .FPGA_I2C_SDAT (sdat)
  );

  initial begin
    clk = 1'b0;
    #40;
    forever #10 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // decoder state
  int          cyc = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  int          bit_cnt = 0;
  logic [7:0]  shreg = 8'h00;
  logic [23:0] frame_buf = 24'h0;
  int          nbytes = 0;
  int          start_cnt = 0;
  int          stop_cnt = 0;
  int          edge_cnt = 0;
  int          first_start_cyc = 0;
  int          last_stop_cyc = 0;
  int          gap_min = 32'h7FFF_FFFF;
  int          gap_max = 0;
  logic [31:0] stop_data [32];

  // Sample the bus on the falling clock edge and decode START/STOP/bits.
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= sclk;
    prev_sda <= sdat;
    if (dec_clr) begin
      bit_cnt         <= 0;
      nbytes          <= 0;
      frame_buf       <= 24'h0;
      start_cnt       <= 0;
      stop_cnt        <= 0;
      edge_cnt        <= 0;
      ack_pull        <= 1'b0;
      first_start_cyc <= 0;
      last_stop_cyc   <= 0;
      gap_min         <= 32'h7FFF_FFFF;
      gap_max         <= 0;
    end else if (prev_scl && sclk && prev_sda && !sdat) begin
      start_cnt <= start_cnt + 1;
      bit_cnt   <= 0;
      nbytes    <= 0;
      frame_buf <= 24'h0;
      if (start_cnt == 0) first_start_cyc <= cyc + 1;
      if (stop_cnt != 0) begin
        if ((cyc + 1 - last_stop_cyc) < gap_min) gap_min <= cyc + 1 - last_stop_cyc;
        if ((cyc + 1 - last_stop_cyc) > gap_max) gap_max <= cyc + 1 - last_stop_cyc;
      end
    end else if (prev_scl && sclk && !prev_sda && sdat) begin
      if (stop_cnt < 32) stop_data[stop_cnt] <= {8'(nbytes), frame_buf};
      stop_cnt      <= stop_cnt + 1;
      last_stop_cyc <= cyc + 1;
    end else if (!prev_scl && sclk) begin
      edge_cnt <= edge_cnt + 1;
      if (bit_cnt < 8) begin
        shreg   <= {shreg[6:0], sdat};
        bit_cnt <= bit_cnt + 1;
        if (bit_cnt == 7) begin
          frame_buf <= {frame_buf[15:0], shreg[6:0], sdat};
          nbytes    <= nbytes + 1;
        end
      end else begin
        bit_cnt <= 0;
      end
    end else if (prev_scl && !sclk) begin
      edge_cnt <= edge_cnt + 1;
      ack_pull <= pull_en && (bit_cnt == 8);
    end
  end

  int rel_cyc = 0;

  task automatic release_key();
    @(negedge clk);
    #2;
    dec_clr = 1'b0;
    rel_cyc = cyc;
    key     = 1'b0;
  endtask

  // Assert KEY between clock edges and check the lines go idle before the next edge.
  task automatic pulse_reset(input string tag);
    dec_clr = 1'b1;
    @(negedge clk);
    #2;
    key = 1'b1;
    #1;
    check_val({tag, "_sclk"}, 32'(sclk), 32'd1);
    check_val({tag, "_sdat"}, 32'(sdat), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cnt(input bit use_stop, input int n, input int budget, input string tag);
    int left;
    left = budget;
    while (((use_stop ? stop_cnt : start_cnt) < n) && (left > 0)) begin
      @(negedge clk);
      left--;
    end
    check_val(tag, 32'((use_stop ? stop_cnt : start_cnt) >= n), 32'd1);
  endtask

  logic [23:0] exp_frame [11] = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217,
                                  24'h340479, 24'h340679, 24'h340812, 24'h340A00,
                                  24'h340E02, 24'h341000, 24'h341201};
  logic [7:0]  addr_bits = 8'b0011_0100;
  int          e0;

  initial begin
    key = 1'b0;
    #2;
    key = 1'b1;
    #3;
    // no clock edge has happened yet
    check_val("rst_sclk", 32'(sclk), 32'd1);
    check_val("rst_sdat", 32'(sdat), 32'd1);

    release_key();
    wait_cnt(1'b1, 1, 600, "frame0_wait");
    check_val("start_delay", 32'(first_start_cyc - rel_cyc), 32'd13);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("addr_bit%0d", 7 - i), 32'(stop_data[0][23 - i]), 32'(addr_bits[7 - i]));
    end

    wait_cnt(1'b1, 11, 4000, "seq_wait");
    repeat (4) @(negedge clk);
    e0 = edge_cnt;
    repeat (200) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      check_val($sformatf("frame%0d", i), stop_data[i], {8'd3, exp_frame[i]});
    end
    check_val("stop_count", 32'(stop_cnt), 32'd11);
    check_val("start_count", 32'(start_cnt), 32'd11);
    check_val("done_no_edges", 32'(edge_cnt - e0), 32'd0);
    check_val("done_sclk", 32'(sclk), 32'd1);
    check_val("done_sdat", 32'(sdat), 32'd1);
    check_val("gap_min", 32'(gap_min), 32'd14);
    check_val("gap_max", 32'(gap_max), 32'd14);

    // mid-transfer reset inside frame 3 while SCLK is low and SDAT driven low
    pulse_reset("rst2");
    release_key();
    wait_cnt(1'b0, 3, 1200, "frame3_wait");
    repeat (36) @(negedge clk);
    check_val("mid_pre_sclk", 32'(sclk), 32'd0);
    check_val("mid_pre_sdat", 32'(sdat), 32'd0);
    pulse_reset("mid_rst");
    release_key();
    wait_cnt(1'b1, 1, 600, "restart_wait");
    check_val("restart_frame", stop_data[0], {8'd3, exp_frame[0]});

    // no acknowledge from the codec: SDAT floats high during ACK
    pulse_reset("rst3");
    pull_en = 1'b0;
    release_key();
    wait_cnt(1'b1, 3, 1500, "float_wait");
`ifdef I2C_ACK_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("nack_retry%0d", i), stop_data[i], {8'd1, 24'h000034});
    end
`else
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("float_frame%0d", i), stop_data[i], {8'd3, exp_frame[i]});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
